// File: rtl/enc_snapshot_sched_pkg.sv
// Shared constants, state encoding and address helpers for the encoder snapshot scheduler.
// Optional build macro: SNAP_TIMESTAMP_EN (timestamp word at snapshot index 15).
package enc_snapshot_sched_pkg;

  localparam logic [3:0] ADDR_MAIN     = 4'h0;
  localparam logic [3:0] OFF_ENC_DATA  = 4'h1;
  localparam logic [3:0] OFF_PER_DATA  = 4'h2;
  localparam logic [3:0] OFF_FREQ_DATA = 4'h3;

  localparam logic [1:0] SNAP_FIELD_ENC  = 2'd0;
  localparam logic [1:0] SNAP_FIELD_PER  = 2'd1;
  localparam logic [1:0] SNAP_FIELD_FREQ = 2'd2;
  localparam logic [3:0] SNAP_TS_IDX     = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHost = 2'd1,
    StSnap = 2'd2,
    StSwap = 2'd3
  } sched_state_e;

  function automatic logic [3:0] field_offset(input logic [1:0] field);
    case (field)
      SNAP_FIELD_ENC:  field_offset = OFF_ENC_DATA;
      SNAP_FIELD_PER:  field_offset = OFF_PER_DATA;
      default:         field_offset = OFF_FREQ_DATA;
    endcase
  endfunction

  // chan is zero-based here; the encoder register map numbers channels from 1.
  function automatic logic [15:0] snap_addr(input logic [1:0] chan, input logic [1:0] field);
    snap_addr = {ADDR_MAIN, 4'h0, {2'b00, chan} + 4'd1, field_offset(field)};
  endfunction

endpackage

// File: rtl/enc_snapshot_sched_dbuf.sv
// Ping-pong 2x16x32 snapshot store: writes go to the back bank, reads come from the front bank.
module snap_dbuf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        swap,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem_q [2][16];
  logic        sel_q;
  logic        back;

  assign back  = ~sel_q;
  assign rdata = mem_q[sel_q][raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 16; w++) begin
          mem_q[b][w] <= 32'h0;
        end
      end
    end else begin
      if (we) mem_q[back][waddr] <= wdata;
      if (swap) sel_q <= ~sel_q;
    end
  end

endmodule

// File: rtl/enc_snapshot_sched.sv
// Shares the encoder read port between a double-buffered snapshot engine and host reads.
// Optional build macro: SNAP_TIMESTAMP_EN.
module enc_snapshot_sched
  import enc_snapshot_sched_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 4,
  parameter int unsigned SEQ_W    = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             sample_req,
  input  logic             host_rd,
  input  logic [15:0]      host_raddr,
  output logic             host_ready,
  output logic [31:0]      host_rdata,
  output logic             host_rvalid,
  output logic [15:0]      enc_raddr,
  input  logic [31:0]      enc_rdata,
  input  logic [3:0]       snap_raddr,
  output logic [31:0]      snap_rdata,
  output logic             snap_valid,
  output logic [SEQ_W-1:0] snap_seq,
  output logic             busy,
  output logic             snap_overrun,
  input  logic             clr_overrun
);

  localparam logic [1:0] LastChan = 2'(NUM_CHAN - 1);

  sched_state_e state_q, state_d;
  logic [1:0]   chan_q, chan_d, field_q, field_d;
  logic         pend_q, pend_d;
  logic [15:0]  addr_q, addr_d;
  logic [31:0]  host_rdata_q;
  logic         host_rvalid_q, valid_q, ovr_q, ovr_set;
  logic [SEQ_W-1:0] seq_q;
  logic         host_acc, accept;
  logic         buf_we, buf_swap;
  logic [3:0]   buf_waddr;
  logic [31:0]  buf_wdata;

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      ts_cnt_q <= 32'h0;
      ts_q     <= 32'h0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (accept) ts_q <= ts_cnt_q;
    end
  end
`endif

  assign host_ready = ~(pend_q | (state_q == StHost));
  assign host_acc   = host_rd & host_ready;
  assign busy       = (state_q == StSnap);
  assign ovr_set    = sample_req & ((state_q == StSnap) | (state_q == StSwap));

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    field_d   = field_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    accept    = 1'b0;
    enc_raddr = 16'h0;
    buf_we    = 1'b0;
    buf_swap  = 1'b0;
    buf_waddr = {chan_q, field_q};
    buf_wdata = enc_rdata;
    unique case (state_q)
      StIdle: begin
        if (sample_req) begin
          accept  = 1'b1;
          state_d = StSnap;
          chan_d  = 2'd0;
          field_d = 2'd0;
          if (host_acc) begin
            pend_d = 1'b1;
            addr_d = host_raddr;
          end
        end else if (host_acc) begin
          state_d = StHost;
          addr_d  = host_raddr;
        end else if (pend_q) begin
          state_d = StHost;
          pend_d  = 1'b0;
        end
      end
      StHost: begin
        enc_raddr = addr_q;
        if (sample_req) begin
          accept  = 1'b1;
          state_d = StSnap;
          chan_d  = 2'd0;
          field_d = 2'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StSnap: begin
        enc_raddr = snap_addr(chan_q, field_q);
        buf_we    = 1'b1;
        if (host_acc) begin
          pend_d = 1'b1;
          addr_d = host_raddr;
        end
        if (field_q == SNAP_FIELD_FREQ) begin
          field_d = 2'd0;
          if (chan_q == LastChan) state_d = StSwap;
          else                    chan_d  = chan_q + 2'd1;
        end else begin
          field_d = field_q + 2'd1;
        end
      end
      StSwap: begin
        buf_swap = 1'b1;
`ifdef SNAP_TIMESTAMP_EN
        buf_we    = 1'b1;
        buf_waddr = SNAP_TS_IDX;
        buf_wdata = ts_q;
`endif
        if (host_acc) addr_d = host_raddr;
        // A waiting host read takes the port straight after the swap.
        if (pend_q | host_acc) begin
          state_d = StHost;
          pend_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q       <= StIdle;
      chan_q        <= 2'd0;
      field_q       <= 2'd0;
      pend_q        <= 1'b0;
      addr_q        <= 16'h0;
      host_rdata_q  <= 32'h0;
      host_rvalid_q <= 1'b0;
      valid_q       <= 1'b0;
      seq_q         <= '0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      field_q       <= field_d;
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      host_rvalid_q <= (state_q == StHost);
      if (state_q == StHost) host_rdata_q <= enc_rdata;
      if (state_q == StSwap) begin
        seq_q   <= seq_q + 1'b1;
        valid_q <= 1'b1;
      end
      ovr_q <= ovr_set | (ovr_q & ~clr_overrun);
    end
  end

  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign snap_valid   = valid_q;
  assign snap_seq     = seq_q;
  assign snap_overrun = ovr_q;

  snap_dbuf u_dbuf (
    .clk   (sysclk),
    .reset (reset),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .swap  (buf_swap),
    .raddr (snap_raddr),
    .rdata (snap_rdata)
  );

endmodule
